// File: rtl/ysyx_24110015_ifu.sv
// Instruction fetch stage: owns the fetch PC, issues one word request at a time,
// and holds the returned instruction for decode. Redirects discard stale fetches.
module ysyx_24110015_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] fetch_pc, fetch_pc_next;
  logic        kill, kill_next;
  logic        inst_valid_next;
  logic [31:0] inst_next, pc_next;
  logic [31:0] redirect_target;
  logic        req_fire;

  assign redirect_target = {redirect_pc[31:2], 2'b00};
  // Gating with rst keeps the request low for the whole reset window, not just after the first edge.
  assign imem_req_valid  = (state == S_REQ) && rst;
  assign imem_req_addr   = fetch_pc;
  assign req_fire        = imem_req_valid && imem_req_ready;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_REQ;
    else      state <= state_next;
  end

  // Next-state logic.
  // NOTE: every combinational output is defaulted first so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_REQ:  if (req_fire) state_next = S_WAIT;
      S_WAIT: if (imem_rsp_valid) state_next = (kill || redirect_valid) ? S_REQ : S_HOLD;
      S_HOLD: if (redirect_valid || inst_ready) state_next = S_REQ;
      default: state_next = S_REQ;
    endcase
  end

  // Datapath next values; a redirect always wins over the sequential +4 advance.
  always_comb begin
    fetch_pc_next   = fetch_pc;
    kill_next       = kill;
    inst_valid_next = inst_valid;
    inst_next       = inst;
    pc_next         = pc;

    if (redirect_valid)
      fetch_pc_next = redirect_target;
    else if (state == S_HOLD && inst_ready)
      fetch_pc_next = fetch_pc + 32'd4;

    unique case (state)
      S_REQ: begin
        // A redirect in the acceptance cycle leaves an old-PC request in flight.
        if (req_fire) kill_next = redirect_valid;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          kill_next = 1'b0;
          if (!kill && !redirect_valid) begin
            inst_next       = imem_rsp_data;
            pc_next         = fetch_pc;
            inst_valid_next = 1'b1;
          end
        end else if (redirect_valid) begin
          kill_next = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid || inst_ready) inst_valid_next = 1'b0;
      end
      default: kill_next = 1'b0;
    endcase
  end

  // Datapath registers; the held instruction is a handful of flops, so it is reset too.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc   <= RESET_PC;
      kill       <= 1'b0;
      inst_valid <= 1'b0;
      inst       <= 32'h0;
      pc         <= 32'h0;
    end else begin
      fetch_pc   <= fetch_pc_next;
      kill       <= kill_next;
      inst_valid <= inst_valid_next;
      inst       <= inst_next;
      pc         <= pc_next;
    end
  end

endmodule
